nand_chain_checker: RTL and testbench



---
 rtl/nand_chain_pkg.sv | 29 ++
 rtl/nand_chain_golden.sv | 14 +
 rtl/nand_chain_checker.sv | 139 +++++++++++++
 tb/tb_nand_chain_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_chain_pkg.sv
// rtl/nand_chain_pkg.sv - shared types, sizes and golden function for the NAND chain self-test
package nand_chain_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int OBS_W       = 3;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // vec is {a,b,c,d}; result is {e,f,g}
    function automatic logic [OBS_W-1:0] nand_chain_expect(input logic [VEC_W-1:0] vec);
        logic e;
        logic f;
        logic g;
        e = ~(vec[3] & vec[2]);
        f = ~(e & vec[1]);
        g = ~(f & vec[0]);
        return {e, f, g};
    endfunction

endpackage

// File: rtl/nand_chain_golden.sv
// rtl/nand_chain_golden.sv - combinational expected {e,f,g} and mismatch flag for one vector
module nand_chain_golden
    import nand_chain_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic [OBS_W-1:0] obs,
    output logic [OBS_W-1:0] expected,
    output logic             mismatch
);

    assign expected = nand_chain_expect(vec);
    assign mismatch = (obs != expected);

endmodule

// File: rtl/nand_chain_checker.sv
// rtl/nand_chain_checker.sv - sweeps all 16 vectors through the NAND chain and records mismatches
module nand_chain_checker
    import nand_chain_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       obs_e,
    input  logic       obs_f,
    input  logic       obs_g,
    output logic       drv_a,
    output logic       drv_b,
    output logic       drv_c,
    output logic       drv_d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_vec,
    output logic [2:0] first_err_obs
);

    state_t           state;
    state_t           state_next;
    logic [VEC_W-1:0] index;
    logic [VEC_W-1:0] index_next;
    logic [3:0]       settle_cnt;
    logic [OBS_W-1:0] obs_vec;
    logic [OBS_W-1:0] unused_expected;
    logic             mismatch;
    logic             sample_bad;
    logic             active_next;
    logic             sweep_accept;

    assign obs_vec = {obs_e, obs_f, obs_g};

    nand_chain_golden u_golden (
        .vec      (index),
        .obs      (obs_vec),
        .expected (unused_expected),
        .mismatch (mismatch)
    );

    always_comb begin
        state_next = state;
        index_next = index;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_DRIVE;
                    index_next = '0;
                end
            end
            ST_DRIVE: begin
                if (abort)                   state_next = ST_IDLE;
                else if (SETTLE_CYCLES == 0) state_next = ST_SAMPLE;
                else                         state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                  state_next = ST_IDLE;
                else if (settle_cnt <= 4'd1) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (index == LAST_VEC) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRIVE;
                    index_next = index + 4'd1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // An aborted sample is dropped rather than counted.
    assign sample_bad   = (state == ST_SAMPLE) && !abort && mismatch;
    assign sweep_accept = (state == ST_IDLE) && (state_next == ST_DRIVE);
    assign active_next  = (state_next == ST_DRIVE) || (state_next == ST_SETTLE) ||
                          (state_next == ST_SAMPLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            index           <= '0;
            settle_cnt      <= '0;
            {drv_a, drv_b, drv_c, drv_d} <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            first_err_obs   <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
            busy  <= active_next;
            done  <= (state_next == ST_DONE);
            {drv_a, drv_b, drv_c, drv_d} <= active_next ? index_next : '0;

            if (state == ST_DRIVE) begin
                settle_cnt <= 4'(SETTLE_CYCLES);
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (sweep_accept) begin
                pass            <= 1'b0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= '0;
                first_err_obs   <= '0;
            end else begin
                if (sample_bad) begin
                    if (err_count != 5'(NUM_VECTORS)) begin
                        err_count <= err_count + 5'd1;
                    end
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= index;
                        first_err_obs   <= obs_vec;
                    end
                end
                // Latched alongside the done pulse so it already includes vector 15.
                if (state_next == ST_DONE) begin
                    pass <= (err_count == 5'd0) && !sample_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_nand_chain_checker.sv
// tb/tb_nand_chain_checker.sv - self-checking bench for nand_chain_checker at SETTLE_CYCLES 2 and 0
module tb_nand_chain_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;

    logic [3:0] drv_s2, drv_s0;
    logic [2:0] obs_s2, obs_s0;
    logic       busy_s2, done_s2, pass_s2, fev_s2;
    logic       busy_s0, done_s0, pass_s0, fev_s0;
    logic [4:0] err_s2, err_s0;
    logic [3:0] fvec_s2, fvec_s0;
    logic [2:0] fobs_s2, fobs_s0;

    logic [2:0] mask [16];

    logic [3:0] tv_vec;
    logic [2:0] tv_obs;
    logic [2:0] tv_exp;
    logic       tv_mis;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nand_chain_checker #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .obs_e(obs_s2[2]), .obs_f(obs_s2[1]), .obs_g(obs_s2[0]),
        .drv_a(drv_s2[3]), .drv_b(drv_s2[2]), .drv_c(drv_s2[1]), .drv_d(drv_s2[0]),
        .busy(busy_s2), .done(done_s2), .pass(pass_s2), .err_count(err_s2),
        .first_err_valid(fev_s2), .first_err_vec(fvec_s2), .first_err_obs(fobs_s2)
    );

    nand_chain_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .obs_e(obs_s0[2]), .obs_f(obs_s0[1]), .obs_g(obs_s0[0]),
        .drv_a(drv_s0[3]), .drv_b(drv_s0[2]), .drv_c(drv_s0[1]), .drv_d(drv_s0[0]),
        .busy(busy_s0), .done(done_s0), .pass(pass_s0), .err_count(err_s0),
        .first_err_valid(fev_s0), .first_err_vec(fvec_s0), .first_err_obs(fobs_s0)
    );

    nand_chain_golden u_gold (
        .vec(tv_vec), .obs(tv_obs), .expected(tv_exp), .mismatch(tv_mis)
    );

    function automatic logic [2:0] ref_chain(input logic [3:0] v);
        logic e, f, g;
        e = !(v[3] && v[2]);
        f = !(e && v[1]);
        g = !(f && v[0]);
        return {e, f, g};
    endfunction

    // Chain as seen by each checker: true NAND outputs with per-vector fault bits flipped.
    always_comb begin
        obs_s2 = ref_chain(drv_s2) ^ mask[drv_s2];
        obs_s0 = ref_chain(drv_s0) ^ mask[drv_s0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic predict(input int upto, output int err, output logic [3:0] fv,
                           output logic [2:0] fo, output logic fvalid);
        err = 0; fv = '0; fo = '0; fvalid = 1'b0;
        for (int v = 0; v < upto; v++) begin
            if (mask[v] != 3'b000) begin
                err++;
                if (!fvalid) begin
                    fvalid = 1'b1;
                    fv     = 4'(v);
                    fo     = ref_chain(4'(v)) ^ mask[v];
                end
            end
        end
    endtask

    task automatic check_res(input string tag, input logic p, input logic [4:0] e,
                             input logic fvl, input logic [3:0] fv, input logic [2:0] fo,
                             input int exp_err, input logic exp_fvl,
                             input logic [3:0] exp_fv, input logic [2:0] exp_fo);
        check({tag, " pass"}, p, (exp_err == 0));
        check({tag, " err_count"}, e, exp_err);
        check({tag, " first_err_valid"}, fvl, exp_fvl);
        check({tag, " first_err_vec"}, fv, exp_fv);
        check({tag, " first_err_obs"}, fo, exp_fo);
    endtask

    // Called just after an active edge; the start pulse is accepted on the next edge (edge 0).
    task automatic run_sweep(input string tag, input int exp_err, input logic exp_fvl,
                             input logic [3:0] exp_fv, input logic [2:0] exp_fo,
                             input int restart_at);
        int at2, at0, n2, n0, b2, b0;
        at2 = -1; at0 = -1; n2 = 0; n0 = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b2 = int'(busy_s2);
        b0 = int'(busy_s0);
        for (int k = 1; k <= 90; k++) begin
            start = (k == restart_at);
            @(posedge clk); #1;
            b2 += int'(busy_s2);
            b0 += int'(busy_s0);
            if (done_s2) begin n2++; if (at2 < 0) at2 = k; end
            if (done_s0) begin n0++; if (at0 < 0) at0 = k; end
        end
        start = 1'b0;
        check({tag, "/s2 done_edge"}, at2, 64);
        check({tag, "/s0 done_edge"}, at0, 32);
        check({tag, "/s2 done_pulses"}, n2, 1);
        check({tag, "/s0 done_pulses"}, n0, 1);
        check({tag, "/s2 busy_cycles"}, b2, 64);
        check({tag, "/s0 busy_cycles"}, b0, 32);
        check({tag, "/s2 drv_idle"}, drv_s2, 0);
        check_res({tag, "/s2"}, pass_s2, err_s2, fev_s2, fvec_s2, fobs_s2,
                  exp_err, exp_fvl, exp_fv, exp_fo);
        check_res({tag, "/s0"}, pass_s0, err_s0, fev_s0, fvec_s0, fobs_s0,
                  exp_err, exp_fvl, exp_fv, exp_fo);
    endtask

    typedef struct {
        logic [3:0] vec;
        logic [2:0] obs;
        logic [2:0] exp;
        logic       mis;
    } gold_vec_t;

    gold_vec_t gtab [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         perr;
        logic [3:0] pfv;
        logic [2:0] pfo;
        logic       pfvl;
        logic [2:0] r;

        gtab[0] = '{4'b0000, 3'b111, 3'b111, 1'b0};
        gtab[1] = '{4'b0001, 3'b110, 3'b110, 1'b0};
        gtab[2] = '{4'b0011, 3'b100, 3'b101, 1'b1};
        gtab[3] = '{4'b0110, 3'b101, 3'b101, 1'b0};
        gtab[4] = '{4'b1010, 3'b000, 3'b101, 1'b1};
        gtab[5] = '{4'b1100, 3'b011, 3'b011, 1'b0};
        gtab[6] = '{4'b1101, 3'b111, 3'b010, 1'b1};
        gtab[7] = '{4'b1110, 3'b011, 3'b011, 1'b0};
        gtab[8] = '{4'b1111, 3'b010, 3'b010, 1'b0};
        gtab[9] = '{4'b1011, 3'b101, 3'b101, 1'b0};

        for (int v = 0; v < 16; v++) mask[v] = 3'b000;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        tv_vec = '0; tv_obs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset s2 outputs", {drv_s2, busy_s2, done_s2, pass_s2, err_s2, fev_s2, fvec_s2, fobs_s2}, 0);
        check("reset s0 outputs", {drv_s0, busy_s0, done_s0, pass_s0, err_s0, fev_s0, fvec_s0, fobs_s0}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tv_vec = gtab[i].vec;
            tv_obs = gtab[i].obs;
            #1;
            check($sformatf("golden expected vec=%b", gtab[i].vec), tv_exp, gtab[i].exp);
            check($sformatf("golden mismatch vec=%b", gtab[i].vec), tv_mis, gtab[i].mis);
        end

        @(posedge clk); #1;
        run_sweep("good+restart", 0, 1'b0, 4'b0000, 3'b000, 10);

        for (int v = 0; v < 16; v++) begin r = ref_chain(4'(v)); mask[v] = {2'b00, r[0]}; end
        run_sweep("g_stuck0", 11, 1'b1, 4'b0000, 3'b110, -1);

        for (int v = 0; v < 16; v++) begin r = ref_chain(4'(v)); mask[v] = {~r[2], 2'b00}; end
        run_sweep("e_stuck1", 4, 1'b1, 4'b1100, 3'b111, -1);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start+abort s2 busy", busy_s2, 0);
        check("start+abort s0 busy", busy_s0, 0);
        check("start+abort s2 results kept", err_s2, 4);

        for (int t = 0; t < 4; t++) begin
            for (int v = 0; v < 16; v++)
                mask[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
            predict(16, perr, pfv, pfo, pfvl);
            run_sweep($sformatf("random%0d", t), perr, pfvl, pfv, pfo, -1);
        end

        for (int v = 0; v < 16; v++)
            mask[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
        predict(7, perr, pfv, pfo, pfvl);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort s2 busy", busy_s2, 0);
        check("abort s2 drv", drv_s2, 0);
        check("abort s2 done", done_s2, 0);
        check("abort s0 busy", busy_s0, 0);
        check("abort s0 drv", drv_s0, 0);
        check("abort s0 pass", pass_s0, 0);
        check("abort s2 pass", pass_s2, 0);
        check("abort s2 err_count", err_s2, perr);
        check("abort s2 first_err_valid", fev_s2, pfvl);
        check("abort s2 first_err_vec", fvec_s2, pfv);
        check("abort s2 first_err_obs", fobs_s2, pfo);
        begin
            int nd;
            nd = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                nd += int'(done_s2) + int'(done_s0);
            end
            check("abort no done", nd, 0);
        end
        for (int v = 0; v < 16; v++) mask[v] = 3'b000;
        run_sweep("after_abort", 0, 1'b0, 4'b0000, 3'b000, -1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (41) @(posedge clk);
        #1;
        check("pre-reset s2 drv vector 10", drv_s2, 10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset s2 outputs", {drv_s2, busy_s2, done_s2, pass_s2, err_s2, fev_s2, fvec_s2, fobs_s2}, 0);
        check("midreset s0 outputs", {drv_s0, busy_s0, done_s0, pass_s0, err_s0, fev_s0, fvec_s0, fobs_s0}, 0);
        run_sweep("after_reset", 0, 1'b0, 4'b0000, 3'b000, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
